// File: rtl/bch_err_apply.sv
`default_nettype none
// ============================================================================
// Module   : bch_err_apply
// Purpose  : Buffers received data words and XORs them with the error-location
//            stream from the Chien search to produce corrected data. Also
//            reports a per-frame corrected-bit count and sticky protocol
//            fault flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   data_in/valid/first   received data words (first-sent bit in LSB)
//   data_ready            FIFO can accept a word
//   err_in/valid/first/last  error-location words (no backpressure)
//   out_data/valid/first/last corrected word stream, 1-cycle latency
//   out_nerr              frame bit-flip total, non-zero only with out_last
//   underrun              sticky: err word arrived while FIFO empty
//   sync_fault            sticky: a first/last marker disagreed with counter
// ============================================================================
module bch_err_apply #(
  parameter int DATA_BITS = 5,
  parameter int BITS      = 1,
  parameter int DEPTH     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BITS-1:0]                    data_in,
  input  logic                               data_valid,
  input  logic                               data_first,
  output logic                               data_ready,
  input  logic [BITS-1:0]                    err_in,
  input  logic                               err_valid,
  input  logic                               err_first,
  input  logic                               err_last,
  output logic [BITS-1:0]                    out_data,
  output logic                               out_valid,
  output logic                               out_first,
  output logic                               out_last,
  output logic [$clog2(DATA_BITS+1)-1:0]     out_nerr,
  output logic                               underrun,
  output logic                               sync_fault
);

  localparam int WORDS = (DATA_BITS + BITS - 1) / BITS;
  localparam int LASTW = DATA_BITS - (WORDS - 1) * BITS;
  localparam int CW    = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] C_LAST_WORD = WCW'(WORDS - 1);

  logic [BITS-1:0] mem_q [DEPTH];

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [WCW-1:0]  icnt_q, icnt_d;
  logic [WCW-1:0]  ocnt_q, ocnt_d;
  logic [CW-1:0]   nerr_q, nerr_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic [CW-1:0]   out_nerr_q, out_nerr_d;
  logic            underrun_q, underrun_d;
  logic            sync_fault_q, sync_fault_d;

  logic            full, empty, wr_en, rd_en;
  logic [BITS-1:0] err_mask, err_m;
  logic [CW-1:0]   pop, nerr_sum;

  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_en = err_valid && !empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted when paired with a read; occupancy stays unchanged.
  assign wr_en = data_valid && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  always_comb begin
    // Only the low LASTW bits of the final word carry data; the rest of the
    // error word is ignored so padding never flips or gets counted.
    err_mask = '1;
    for (int i = 0; i < BITS; i++) begin
      err_mask[i] = (ocnt_q != C_LAST_WORD) || (i < LASTW);
    end
    err_m = err_in & err_mask;
    pop   = '0;
    for (int i = 0; i < BITS; i++) begin
      pop = pop + CW'(err_m[i]);
    end
    nerr_sum = nerr_q + pop;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    icnt_d       = icnt_q;
    ocnt_d       = ocnt_q;
    nerr_d       = nerr_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_first_d  = 1'b0;
    out_last_d   = 1'b0;
    out_nerr_d   = '0;
    underrun_d   = underrun_q;
    sync_fault_d = sync_fault_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (data_first && icnt_q != '0) begin
        // Trust the marker: this word is word 0, so the next one is word 1.
        sync_fault_d = 1'b1;
        icnt_d       = (WORDS == 1) ? '0 : WCW'(1);
      end else begin
        if (!data_first && icnt_q == '0) sync_fault_d = 1'b1;
        icnt_d = (icnt_q == C_LAST_WORD) ? '0 : icnt_q + 1'b1;
      end
    end

    if (err_valid && empty) begin
      underrun_d = 1'b1;
    end

    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_data_d  = mem_q[rd_ptr_q[AW-1:0]] ^ err_m;
      out_valid_d = 1'b1;
      out_first_d = (ocnt_q == '0);
      out_last_d  = (ocnt_q == C_LAST_WORD);
      if (err_first && ocnt_q != '0)         sync_fault_d = 1'b1;
      if (err_last && ocnt_q != C_LAST_WORD) sync_fault_d = 1'b1;
      if (ocnt_q == C_LAST_WORD) begin
        ocnt_d     = '0;
        nerr_d     = '0;
        out_nerr_d = nerr_sum;
      end else begin
        ocnt_d = ocnt_q + 1'b1;
        nerr_d = nerr_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      icnt_q       <= '0;
      ocnt_q       <= '0;
      nerr_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_nerr_q   <= '0;
      underrun_q   <= 1'b0;
      sync_fault_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      icnt_q       <= icnt_d;
      ocnt_q       <= ocnt_d;
      nerr_q       <= nerr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_nerr_q   <= out_nerr_d;
      underrun_q   <= underrun_d;
      sync_fault_q <= sync_fault_d;
    end
  end

  assign data_ready = !full;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_nerr   = out_nerr_q;
  assign underrun   = underrun_q;
  assign sync_fault = sync_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_err_apply.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_err_apply
// Purpose  : Directed self-checking bench for bch_err_apply. Instance A uses
//            DATA_BITS=10, BITS=4, DEPTH=4; instance B uses DATA_BITS=5,
//            BITS=1, DEPTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_err_apply;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic [3:0] a_data_in = '0, a_err_in = '0, a_out_data;
  logic a_data_valid = 0, a_data_first = 0, a_data_ready;
  logic a_err_valid = 0, a_err_first = 0, a_err_last = 0;
  logic a_out_valid, a_out_first, a_out_last, a_underrun, a_sync_fault;
  logic [3:0] a_out_nerr;

  // Instance B signals
  logic [0:0] b_data_in = '0, b_err_in = '0, b_out_data;
  logic b_data_valid = 0, b_data_first = 0, b_data_ready;
  logic b_err_valid = 0, b_err_first = 0, b_err_last = 0;
  logic b_out_valid, b_out_first, b_out_last, b_underrun, b_sync_fault;
  logic [2:0] b_out_nerr;

  int checks = 0;
  int failures = 0;

  bch_err_apply #(.DATA_BITS(10), .BITS(4), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset),
    .data_in(a_data_in), .data_valid(a_data_valid), .data_first(a_data_first),
    .data_ready(a_data_ready),
    .err_in(a_err_in), .err_valid(a_err_valid), .err_first(a_err_first),
    .err_last(a_err_last),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_first(a_out_first),
    .out_last(a_out_last), .out_nerr(a_out_nerr),
    .underrun(a_underrun), .sync_fault(a_sync_fault)
  );

  bch_err_apply #(.DATA_BITS(5), .BITS(1), .DEPTH(16)) u_b (
    .clk(clk), .reset(reset),
    .data_in(b_data_in), .data_valid(b_data_valid), .data_first(b_data_first),
    .data_ready(b_data_ready),
    .err_in(b_err_in), .err_valid(b_err_valid), .err_first(b_err_first),
    .err_last(b_err_last),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_first(b_out_first),
    .out_last(b_out_last), .out_nerr(b_out_nerr),
    .underrun(b_underrun), .sync_fault(b_sync_fault)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic dv, input logic [3:0] d, input logic df,
                         input logic ev, input logic [3:0] e,
                         input logic ef, input logic el);
    a_data_valid = dv; a_data_in = d; a_data_first = df;
    a_err_valid = ev; a_err_in = e; a_err_first = ef; a_err_last = el;
  endtask

  task automatic do_reset();
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
    b_data_valid = 0; b_err_valid = 0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 4'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", a_out_data); end
    checks++; if (a_data_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", a_data_ready); end
    checks++; if ({a_underrun, a_sync_fault, a_out_nerr} !== 6'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0", {a_underrun, a_sync_fault, a_out_nerr}); end
    checks++; if (b_data_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%b exp=1", b_data_ready); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    a_drive(1, 4'h5, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'hA, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h3, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h1, 1, 0); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_last, a_out_data, a_out_nerr} !== {3'b110, 4'h4, 4'd0}) begin failures++; $display("FAIL basic_w0 got=%b exp=%b", {a_out_valid, a_out_first, a_out_last, a_out_data, a_out_nerr}, {3'b110, 4'h4, 4'd0}); end
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 0); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_last, a_out_data} !== {3'b100, 4'hA}) begin failures++; $display("FAIL basic_w1 got=%b exp=%b", {a_out_valid, a_out_first, a_out_last, a_out_data}, {3'b100, 4'hA}); end
    a_drive(0, 4'h0, 0, 1, 4'hF, 0, 1); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_last, a_out_data} !== {3'b101, 4'h0}) begin failures++; $display("FAIL basic_w2 got=%b exp=%b", {a_out_valid, a_out_first, a_out_last, a_out_data}, {3'b101, 4'h0}); end
    checks++; if (a_out_nerr !== 4'd3) begin failures++; $display("FAIL basic_nerr got=%0d exp=3", a_out_nerr); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
    checks++; if ({a_out_valid, a_out_nerr, a_underrun, a_sync_fault} !== 7'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", {a_out_valid, a_out_nerr, a_underrun, a_sync_fault}); end
  endtask

  task automatic test_full_rw();
    logic [3:0] exp_d [5];
    logic       exp_f [5];
    logic       exp_l [5];
    exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_f = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    a_drive(1, 4'h1, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h2, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h3, 0, 0, 4'h0, 0, 0); cyc();
    checks++; if (a_data_ready !== 1'b1) begin failures++; $display("FAIL full_ready3 got=%b exp=1", a_data_ready); end
    a_drive(1, 4'h4, 1, 0, 4'h0, 0, 0); cyc();
    checks++; if (a_data_ready !== 1'b0) begin failures++; $display("FAIL full_ready4 got=%b exp=0", a_data_ready); end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) a_drive(1, 4'h5, 0, 1, 4'h0, exp_f[i], exp_l[i]);
      else        a_drive(0, 4'h0, 0, 1, 4'h0, exp_f[i], exp_l[i]);
      cyc();
      checks++; if ({a_out_valid, a_out_first, a_out_last, a_out_data} !== {1'b1, exp_f[i], exp_l[i], exp_d[i]}) begin failures++; $display("FAIL full_rd%0d got=%b exp=%b", i, {a_out_valid, a_out_first, a_out_last, a_out_data}, {1'b1, exp_f[i], exp_l[i], exp_d[i]}); end
      if (i == 0) begin
        checks++; if (a_data_ready !== 1'b0) begin failures++; $display("FAIL full_ready_rw got=%b exp=0", a_data_ready); end
      end
    end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
    checks++; if ({a_data_ready, a_underrun, a_sync_fault} !== 3'b100) begin failures++; $display("FAIL full_end got=%b exp=100", {a_data_ready, a_underrun, a_sync_fault}); end
  endtask

  task automatic test_underrun();
    do_reset();
    a_drive(0, 4'h0, 0, 1, 4'h7, 0, 0); cyc();
    checks++; if ({a_out_valid, a_underrun} !== 2'b01) begin failures++; $display("FAIL unr_flag got=%b exp=01", {a_out_valid, a_underrun}); end
    a_drive(1, 4'h6, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h9, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'hC, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h2, 1, 0); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_data} !== {2'b11, 4'h4}) begin failures++; $display("FAIL unr_w0 got=%b exp=%b", {a_out_valid, a_out_first, a_out_data}, {2'b11, 4'h4}); end
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 1); cyc();
    checks++; if ({a_out_valid, a_out_last, a_out_data, a_out_nerr} !== {2'b11, 4'hC, 4'd1}) begin failures++; $display("FAIL unr_w2 got=%b exp=%b", {a_out_valid, a_out_last, a_out_data, a_out_nerr}, {2'b11, 4'hC, 4'd1}); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
  endtask

  task automatic test_err_sync();
    do_reset();
    a_drive(1, 4'h1, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h2, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h3, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h0, 1, 0); cyc();
    checks++; if ({a_out_first, a_sync_fault} !== 2'b10) begin failures++; $display("FAIL esync_w0 got=%b exp=10", {a_out_first, a_sync_fault}); end
    a_drive(0, 4'h0, 0, 1, 4'h0, 1, 0); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_data, a_sync_fault} !== {2'b10, 4'h2, 1'b1}) begin failures++; $display("FAIL esync_w1 got=%b exp=%b", {a_out_valid, a_out_first, a_out_data, a_sync_fault}, {2'b10, 4'h2, 1'b1}); end
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 1); cyc();
    checks++; if ({a_out_first, a_out_last, a_out_data} !== {2'b01, 4'h3}) begin failures++; $display("FAIL esync_w2 got=%b exp=%b", {a_out_first, a_out_last, a_out_data}, {2'b01, 4'h3}); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
  endtask

  task automatic test_in_sync();
    do_reset();
    a_drive(1, 4'h1, 0, 0, 4'h0, 0, 0); cyc();
    checks++; if (a_sync_fault !== 1'b1) begin failures++; $display("FAIL isync_nofirst got=%b exp=1", a_sync_fault); end
    do_reset();
    a_drive(1, 4'h1, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h2, 1, 0, 4'h0, 0, 0); cyc();
    checks++; if (a_sync_fault !== 1'b1) begin failures++; $display("FAIL isync_midfirst got=%b exp=1", a_sync_fault); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h8, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h8, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h8, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h1, 1, 0); cyc();
    checks++; if ({a_out_valid, a_out_data, a_underrun} !== {1'b1, 4'h9, 1'b1}) begin failures++; $display("FAIL mid_pre got=%b exp=%b", {a_out_valid, a_out_data, a_underrun}, {1'b1, 4'h9, 1'b1}); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if ({a_out_valid, a_data_ready, a_underrun, a_sync_fault} !== 4'b0100) begin failures++; $display("FAIL mid_async got=%b exp=0100", {a_out_valid, a_data_ready, a_underrun, a_sync_fault}); end
    cyc();
    reset = 1'b0;
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 0); cyc();
    checks++; if ({a_out_valid, a_underrun} !== 2'b01) begin failures++; $display("FAIL mid_empty got=%b exp=01", {a_out_valid, a_underrun}); end
    do_reset();
    a_drive(1, 4'h0, 1, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(1, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'hF, 1, 0); cyc();
    checks++; if ({a_out_valid, a_out_first, a_out_data} !== {2'b11, 4'hF}) begin failures++; $display("FAIL mid_w0 got=%b exp=%b", {a_out_valid, a_out_first, a_out_data}, {2'b11, 4'hF}); end
    a_drive(0, 4'h0, 0, 1, 4'h0, 0, 0); cyc();
    a_drive(0, 4'h0, 0, 1, 4'h1, 0, 1); cyc();
    checks++; if ({a_out_last, a_out_data, a_out_nerr} !== {1'b1, 4'h1, 4'd5}) begin failures++; $display("FAIL mid_w2 got=%b exp=%b", {a_out_last, a_out_data, a_out_nerr}, {1'b1, 4'h1, 4'd5}); end
    a_drive(0, 4'h0, 0, 0, 4'h0, 0, 0); cyc();
  endtask

  task automatic test_bit_serial();
    logic [4:0] dbits, ebits, obits;
    dbits = 5'b01101;  // bit i = word i: 1,0,1,1,0
    ebits = 5'b10100;  // 0,0,1,0,1
    obits = 5'b11001;  // 1,0,0,1,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_data_valid = 1; b_data_in = dbits[i]; b_data_first = (i == 0);
      cyc();
    end
    b_data_valid = 0; b_data_first = 0;
    for (int i = 0; i < 5; i++) begin
      b_err_valid = 1; b_err_in = ebits[i]; b_err_first = (i == 0); b_err_last = (i == 4);
      cyc();
      checks++; if ({b_out_valid, b_out_first, b_out_last, b_out_data} !== {1'b1, (i == 0), (i == 4), obits[i]}) begin failures++; $display("FAIL serial_b%0d got=%b exp=%b", i, {b_out_valid, b_out_first, b_out_last, b_out_data}, {1'b1, (i == 0), (i == 4), obits[i]}); end
    end
    checks++; if ({b_out_nerr, b_underrun, b_sync_fault} !== {3'd2, 2'b00}) begin failures++; $display("FAIL serial_nerr got=%b exp=%b", {b_out_nerr, b_underrun, b_sync_fault}, {3'd2, 2'b00}); end
    b_err_valid = 0; b_err_first = 0; b_err_last = 0;
    cyc();
    checks++; if ({b_out_valid, b_out_nerr} !== 4'b0) begin failures++; $display("FAIL serial_idle got=%b exp=0", {b_out_valid, b_out_nerr}); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_full_rw();
    test_underrun();
    test_err_sync();
    test_in_sync();
    test_reset_mid();
    test_bit_serial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
